tcam_rule_upd_ctrl: RTL
=======================

Name: tcam_rule_upd_ctrl

Overview:
- Read-modify-write sequencer that installs or deletes one ternary rule in a RAM-based TCAM slice.
- The slice is one simple-dual-port RAM: DEP words of WID bits, 1-cycle read latency, address = key chunk, bit r = rule r matches that chunk.
- Shares the RAM read port between external lookups, which have priority, and its own update reads.
- Sits between the TCAM management interface and each RAM slice; one instance per slice.

Parameters:
- WID, 4: rules per slice; RAM word width.
- RIW, 2: rule-index width; must satisfy 2**RIW >= WID.
- AWID, 2: key-chunk width; RAM address width.
- DEP, 1<<AWID: RAM depth.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  update request.
- req_ready  out  1  controller idle; accepts a request when req_valid is also high.
- req_rule  in  RIW  rule index (bit position) to update.
- req_val  in  AWID  rule value chunk.
- req_mask  in  AWID  care mask (1 = compare bit).
- req_del  in  1  1 = delete the rule (clear its bit at every address).
- req_flush  in  1  flush command (optional feature).
- upd_done  out  1  one-cycle pulse when an update completes.
- lk_valid  in  1  lookup request.
- lk_key  in  AWID  lookup key chunk.
- lk_rvalid  out  1  lk_rdo valid; asserted the cycle after an accepted lookup.
- lk_rdo  out  WID  match vector; equals ram_rdo.
- ram_ra  out  AWID  RAM read address.
- ram_rdo  in  WID  RAM read data, 1-cycle latency.
- ram_wa  out  AWID  RAM write address.
- ram_wdi  out  WID  RAM write data.
- ram_we  out  1  RAM write enable.

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE; address counter = 0; lk_rvalid = 0; upd_done = 0; ram_we = 0.
  - req_ready = 1 once rst deasserts.
  - A reset mid-update abandons the update; a partially written rule stays in RAM.
- States: IDLE, RD, WR, DONE; FLUSH exists only with the optional feature.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch rule, val, mask and del; addr = 0; go to RD.
- RD:
  - If lk_valid = 0: ram_ra = addr; go to WR.
  - If lk_valid = 1: the lookup owns ram_ra; stay in RD. Stalls are unbounded.
- WR:
  - ram_rdo holds the word at addr.
  - ram_we = 1, ram_wa = addr.
  - ram_wdi = ram_rdo with bit rule replaced by m; all other bits unchanged.
  - m = ~del & (((addr ^ val) & mask) == 0).
  - If addr == DEP-1: go to DONE. Otherwise addr + 1, go to RD.
  - The read port is free in WR; a lookup is serviced without stalling.
- DONE:
  - upd_done = 1, req_ready = 0; go to IDLE next cycle.
- Latency without stalls: handshake in cycle T; upd_done in cycle T + 2*DEP + 1.
- Lookups:
  - Whenever lk_valid = 1 in any state except RD-granted, ram_ra = lk_key. In RD, lookup always wins.
  - lk_rvalid is registered lk_valid.
- Consistency: a lookup during an update may see a partially updated rule; this is permitted. Caller serialises consistency externally.
- req_rule >= WID: the request is accepted and sequenced, but no bit changes (ram_wdi = ram_rdo).
- Request inputs are ignored outside IDLE.
- ram_we is 0 in every state other than WR and FLUSH.

Optional Feature:
- Macro: TCAM_UPD_FLUSH_EN.
- With the macro:
  - In IDLE, req_valid & req_flush goes to FLUSH.
  - FLUSH writes all-zero words to addresses 0..DEP-1, one per cycle, with no reads, then goes to DONE.
  - Latency is DEP + 1 cycles from the handshake.
  - req_flush has priority over req_rule and req_del.
- Without the macro: req_flush is ignored, and the FLUSH state and its logic are absent.

Decomposition:
- Shared package tcam_pkg holds:
  - the state encoding constants (IDLE=0, RD=1, WR=2, DONE=3, FLUSH=4);
  - the match-bit function (addr, val, mask) -> bit.
- One sub-module is natural: tcam_rd_arb, the read-port mux plus lk_rvalid register.

Test Plan:
- Install, WID=4, AWID=2, RAM all-zero: rule=1, val=2'b10, mask=2'b10 -> words 0,1 = 4'h0; words 2,3 = 4'h2; upd_done at T+9.
- Delete after install: same rule, req_del=1 -> all four words 4'h0; bits of other rules preserved (preload 4'h5 -> 4'h5 after).
- Lookup contention: lk_valid held 3 cycles while in RD -> update stalls 3 cycles; upd_done at T+12; lk_rvalid and lk_rdo correct each cycle.
- Full-wildcard rule: rule=3, mask=0 -> every word gets bit 3 set (4'h8); rule=0, mask=2'b11, val=2'b01 -> only word 1 gets bit 0.
- Async reset asserted mid-WR -> ram_we drops immediately, req_ready = 1 after release, next request runs normally.
- With TCAM_UPD_FLUSH_EN: preload 4'hF, req_flush -> 4 writes of 4'h0 on consecutive cycles, upd_done at T+5. Without the macro: the same stimulus performs a normal rule update.

Source files
------------

// File: rtl/tcam_pkg.sv
// Shared definitions for the TCAM rule update controller:
// sequencer state encoding and the per-address rule match function.
package tcam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WR    = 3'd2,
    ST_DONE  = 3'd3,
    ST_FLUSH = 3'd4
  } upd_state_e;

  // Operand width for the match function; callers zero-extend narrower chunks.
  localparam int unsigned MATCH_W = 32;

  // A rule covers an address when every cared-for bit of the address equals the rule value.
  function automatic logic rule_match(input logic [MATCH_W-1:0] addr,
                                      input logic [MATCH_W-1:0] val,
                                      input logic [MATCH_W-1:0] mask);
    return (((addr ^ val) & mask) == {MATCH_W{1'b0}});
  endfunction

endpackage

// File: rtl/tcam_rd_arb.sv
// Read-port arbiter for one TCAM slice: external lookups always win the RAM
// read address; the update sequencer is granted only when no lookup is present.
module tcam_rd_arb
  import tcam_pkg::*;
#(
  parameter int AWID = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            upd_rd_req,
  input  logic [AWID-1:0] upd_addr,
  input  logic            lk_valid,
  input  logic [AWID-1:0] lk_key,
  output logic [AWID-1:0] ram_ra,
  output logic            upd_rd_gnt,
  output logic            lk_rvalid
);

  logic lk_rvalid_q;
  logic lk_rvalid_d;

  // Grant the read port to the sequencer only in a lookup-free cycle.
  always_comb begin
    upd_rd_gnt  = upd_rd_req & ~lk_valid;
    lk_rvalid_d = lk_valid;
    if (upd_rd_gnt) begin
      ram_ra = upd_addr;
    end else begin
      ram_ra = lk_key;
    end
  end

  // Lookup data returns one cycle after the address, so delay the valid to match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_rvalid_q <= 1'b0;
    end else begin
      lk_rvalid_q <= lk_rvalid_d;
    end
  end

  assign lk_rvalid = lk_rvalid_q;

endmodule

// File: rtl/tcam_rule_upd_ctrl.sv
// Read-modify-write sequencer that installs or deletes one ternary rule in a
// RAM-based TCAM slice. Each address is read, the rule's bit is replaced by
// the match result for that address, and the word is written back.
// Optional feature: define TCAM_UPD_FLUSH_EN to add a flush command that
// zeroes the whole slice without reading it.
module tcam_rule_upd_ctrl
  import tcam_pkg::*;
#(
  parameter int WID  = 4,
  parameter int RIW  = 2,
  parameter int AWID = 2,
  parameter int DEP  = 1 << AWID
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [RIW-1:0]  req_rule,
  input  logic [AWID-1:0] req_val,
  input  logic [AWID-1:0] req_mask,
  input  logic            req_del,
  input  logic            req_flush,
  output logic            upd_done,
  input  logic            lk_valid,
  input  logic [AWID-1:0] lk_key,
  output logic            lk_rvalid,
  output logic [WID-1:0]  lk_rdo,
  output logic [AWID-1:0] ram_ra,
  input  logic [WID-1:0]  ram_rdo,
  output logic [AWID-1:0] ram_wa,
  output logic [WID-1:0]  ram_wdi,
  output logic            ram_we
);

  upd_state_e      state_q, state_d;
  logic [AWID-1:0] addr_q, addr_d;
  logic [RIW-1:0]  rule_q, rule_d;
  logic [AWID-1:0] val_q, val_d;
  logic [AWID-1:0] mask_q, mask_d;
  logic            del_q, del_d;
  logic            upd_rd_gnt;
  logic            addr_last;
  logic            m_bit;

`ifndef TCAM_UPD_FLUSH_EN
  // The flush command has no effect in this build.
  logic unused_flush;
  assign unused_flush = req_flush;
`endif

  tcam_rd_arb #(
    .AWID (AWID)
  ) u_rd_arb (
    .clk        (clk),
    .rst        (rst),
    .upd_rd_req (state_q == ST_RD),
    .upd_addr   (addr_q),
    .lk_valid   (lk_valid),
    .lk_key     (lk_key),
    .ram_ra     (ram_ra),
    .upd_rd_gnt (upd_rd_gnt),
    .lk_rvalid  (lk_rvalid)
  );

  assign lk_rdo    = ram_rdo;
  assign addr_last = (addr_q == AWID'(DEP - 1));
  assign m_bit     = ~del_q & rule_match(32'(addr_q), 32'(val_q), 32'(mask_q));

  // State and latched request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rule_q  <= '0;
      val_q   <= '0;
      mask_q  <= '0;
      del_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rule_q  <= rule_d;
      val_q   <= val_d;
      mask_q  <= mask_d;
      del_q   <= del_d;
    end
  end

  // Next-state and address sequencing; request fields are captured only in IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rule_d  = rule_q;
    val_d   = val_q;
    mask_d  = mask_q;
    del_d   = del_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rule_d = req_rule;
          val_d  = req_val;
          mask_d = req_mask;
          del_d  = req_del;
          addr_d = '0;
`ifdef TCAM_UPD_FLUSH_EN
          if (req_flush) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_RD;
          end
`else
          state_d = ST_RD;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        // A lookup in this cycle takes the read port; retry next cycle.
        if (upd_rd_gnt) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_WR: begin
        if (addr_last) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + AWID'(1);
          state_d = ST_RD;
        end
      end
`ifdef TCAM_UPD_FLUSH_EN
      ST_FLUSH: begin
        if (addr_last) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + AWID'(1);
          state_d = ST_FLUSH;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state; the write word is the read word
  // with only the selected rule bit replaced (an out-of-range rule changes nothing).
  always_comb begin
    req_ready = 1'b0;
    upd_done  = 1'b0;
    ram_we    = 1'b0;
    ram_wa    = addr_q;
    ram_wdi   = ram_rdo;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
      end
      ST_WR: begin
        ram_we = 1'b1;
        for (int i = 0; i < WID; i++) begin
          if (rule_q == RIW'(i)) begin
            ram_wdi[i] = m_bit;
          end else begin
            ram_wdi[i] = ram_rdo[i];
          end
        end
      end
`ifdef TCAM_UPD_FLUSH_EN
      ST_FLUSH: begin
        ram_we  = 1'b1;
        ram_wdi = '0;
      end
`endif
      ST_DONE: begin
        upd_done = 1'b1;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

endmodule
